// File: rtl/rand_victim_select_pkg.sv
// Shared fetch-side types for victim selection: FSM states, result status codes
// and the default way-index width.
package rand_victim_select_pkg;

  localparam int VICTIM_WAY_WIDTH = $clog2(4);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_SCAN   = 2'd2,
    ST_DONE   = 2'd3
  } victim_state_e;

  typedef enum logic [1:0] {
    VS_INVALID_PICK = 2'd0,
    VS_RANDOM       = 2'd1,
    VS_SCAN         = 2'd2,
    VS_NONE         = 2'd3
  } victim_status_e;

endpackage

// File: rtl/rand_victim_select_rot_prio_enc.sv
// Rotating priority encoder: first set bit of mask at or after start, wrapping.
// Purely combinational; no flow control.
module rot_prio_enc #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] mask,
  input  logic [W-1:0] start,
  output logic [W-1:0] index,
  output logic         found
);

  logic [W-1:0] idx;

  // Walk offsets high to low so the smallest offset from start wins.
  always_comb begin
    index = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = start + W'(i);
      if (mask[idx]) begin
        index = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rand_victim_select.sv
// Victim way picker: free way first, then LFSR samples past locked ways, then scan.
// Latency 1 (free/none), 2+ (random), worst 1+MAX_RETRY+1; result held until victim_ack.
module rand_victim_select
  import rand_victim_select_pkg::*;
#(
  parameter int WAYS       = 4,
  parameter int RAND_WIDTH = 32,
  parameter int MAX_RETRY  = 3,
  localparam int W  = $clog2(WAYS),
  localparam int RW = $clog2(MAX_RETRY + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [WAYS-1:0]       way_valid,
  input  logic [WAYS-1:0]       way_lock,
  input  logic [RAND_WIDTH-1:0] randomval,
  output logic                  lfsr_update,
  output logic                  victim_valid,
  output logic [W-1:0]          victim_way,
  output logic [1:0]            victim_status,
  input  logic                  victim_ack
);

  victim_state_e  state, state_n;
  victim_status_e status_q, status_n;
  logic [WAYS-1:0] lock_q, lock_n;
  logic [RW-1:0]   retry_q, retry_n, retry_inc;
  logic [W-1:0]    last_q, last_n, way_q, way_n;
  logic [W-1:0]    cand, free_idx, scan_idx, scan_start;
  logic            free_found;
  logic            unused_scan_found;
  logic            unused_rand_hi;

  assign cand           = randomval[W-1:0];
  assign unused_rand_hi = ^randomval[RAND_WIDTH-1:W];
  assign retry_inc      = retry_q + RW'(1);
  assign scan_start     = last_q + W'(1);

  rot_prio_enc #(.N(WAYS)) u_free_enc (
    .mask  (~way_valid & ~way_lock),
    .start ('0),
    .index (free_idx),
    .found (free_found)
  );

  rot_prio_enc #(.N(WAYS)) u_scan_enc (
    .mask  (~lock_q),
    .start (scan_start),
    .index (scan_idx),
    .found (unused_scan_found)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      status_q <= VS_INVALID_PICK;
      lock_q   <= '0;
      retry_q  <= '0;
      last_q   <= '0;
      way_q    <= '0;
    end else begin
      state    <= state_n;
      status_q <= status_n;
      lock_q   <= lock_n;
      retry_q  <= retry_n;
      last_q   <= last_n;
      way_q    <= way_n;
    end
  end

  always_comb begin
    state_n  = state;
    status_n = status_q;
    lock_n   = lock_q;
    retry_n  = retry_q;
    last_n   = last_q;
    way_n    = way_q;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          lock_n = way_lock;
          if (free_found) begin
            way_n    = free_idx;
            status_n = VS_INVALID_PICK;
            state_n  = ST_DONE;
          end else if (&way_lock) begin
            way_n    = '0;
            status_n = VS_NONE;
            state_n  = ST_DONE;
          end else begin
            retry_n = '0;
            state_n = ST_SAMPLE;
          end
        end
      end
      ST_SAMPLE: begin
        if (!lock_q[cand]) begin
          way_n    = cand;
          status_n = VS_RANDOM;
          state_n  = ST_DONE;
        end else begin
          retry_n = retry_inc;
          if (retry_inc == RW'(MAX_RETRY)) begin
            last_n  = cand;
            state_n = ST_SCAN;
          end
        end
      end
      // An unlocked way always exists here; the all-locked case left via IDLE.
      ST_SCAN: begin
        way_n    = scan_idx;
        status_n = VS_SCAN;
        state_n  = ST_DONE;
      end
      ST_DONE: begin
        if (victim_ack) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign req_ready     = (state == ST_IDLE);
  assign lfsr_update   = (state == ST_SAMPLE);
  assign victim_valid  = (state == ST_DONE);
  assign victim_way    = way_q;
  assign victim_status = status_q;

endmodule

// File: tb/tb_rand_victim_select.sv
// Directed bench for rand_victim_select (WAYS=4, MAX_RETRY=3); the LFSR is modelled
// as an incrementing value advanced on every lfsr_update pulse.
module tb_rand_victim_select;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  way_valid;
  logic [3:0]  way_lock;
  logic [31:0] randomval;
  logic        lfsr_update;
  logic        victim_valid;
  logic [1:0]  victim_way;
  logic [1:0]  victim_status;
  logic        victim_ack;

  int n_checks = 0;
  int n_fail   = 0;
  int lat, ups;

  rand_victim_select #(.WAYS(4), .RAND_WIDTH(32), .MAX_RETRY(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .way_valid     (way_valid),
    .way_lock      (way_lock),
    .randomval     (randomval),
    .lfsr_update   (lfsr_update),
    .victim_valid  (victim_valid),
    .victim_way    (victim_way),
    .victim_status (victim_status),
    .victim_ack    (victim_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},     32'(req_ready),     32'd1);
    check({tag, "_lfsr_update"},   32'(lfsr_update),   32'd0);
    check({tag, "_victim_valid"},  32'(victim_valid),  32'd0);
    check({tag, "_victim_way"},    32'(victim_way),    32'd0);
    check({tag, "_victim_status"}, 32'(victim_status), 32'd0);
  endtask

  // Present a request for one edge, then scramble the masks so the DUT must
  // rely on what it captured at acceptance.
  task automatic request(input string tag, input logic [3:0] v, input logic [3:0] l);
    way_valid = v;
    way_lock  = l;
    req_valid = 1'b1;
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    way_valid = ~v;
    way_lock  = ~l;
  endtask

  // Count cycles from acceptance to victim_valid (1 = visible right after the
  // accepting edge) and lfsr_update pulses; bounded at 20 cycles.
  task automatic wait_done(output int cycles, output int pulses);
    logic upd;
    cycles = 1;
    pulses = 0;
    while (victim_valid !== 1'b1 && cycles < 20) begin
      upd = lfsr_update;
      if (upd === 1'b1) pulses++;
      @(posedge clk); #1;
      if (upd === 1'b1) randomval = randomval + 32'd1;
      cycles++;
    end
    if (cycles >= 20) check("done_timeout", 32'(victim_valid), 32'd1);
  endtask

  task automatic ack(input string tag);
    victim_ack = 1'b1;
    @(posedge clk); #1;
    victim_ack = 1'b0;
    check({tag, "_ready_after_ack"}, 32'(req_ready), 32'd1);
    check({tag, "_valid_after_ack"}, 32'(victim_valid), 32'd0);
  endtask

  task automatic expect_result(input string tag, input int exp_lat, input int exp_ups,
                               input logic [1:0] exp_way, input logic [1:0] exp_status);
    wait_done(lat, ups);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_lfsr_pulses"}, 32'(ups), 32'(exp_ups));
    check({tag, "_way"}, 32'(victim_way), 32'(exp_way));
    check({tag, "_status"}, 32'(victim_status), 32'(exp_status));
  endtask

  initial begin
    rst        = 1'b0;
    req_valid  = 1'b0;
    way_valid  = 4'h0;
    way_lock   = 4'h0;
    randomval  = 32'h0;
    victim_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // Lowest free way is 2.
    request("invalid_pick", 4'b1011, 4'b0000);
    expect_result("invalid_pick", 1, 0, 2'd2, 2'd0);
    ack("invalid_pick");

    // All valid, nothing locked: first sample (low bits 01) wins.
    randomval = 32'hFFFF_FFFD;
    request("random", 4'b1111, 4'b0000);
    check("random_sample_strobe", 32'(lfsr_update), 32'd1);
    check("random_sample_not_ready", 32'(req_ready), 32'd0);
    expect_result("random", 2, 1, 2'd1, 2'd1);
    ack("random");

    // Samples 0,1,2 all locked -> scan from 3 finds way 3.
    randomval = 32'hA5A5_5A54;
    request("scan", 4'b1111, 4'b0111);
    expect_result("scan", 5, 3, 2'd3, 2'd2);

    // Hold the result while inputs churn.
    for (int i = 0; i < 10; i++) begin
      way_lock  = 4'($urandom);
      way_valid = 4'($urandom);
      randomval = $urandom;
      @(posedge clk); #1;
      check("hold_way", 32'(victim_way), 32'd3);
      check("hold_status", 32'(victim_status), 32'd2);
      check("hold_valid", 32'(victim_valid), 32'd1);
      check("hold_ready", 32'(req_ready), 32'd0);
      check("hold_no_strobe", 32'(lfsr_update), 32'd0);
    end
    ack("scan");

    // Every way locked.
    request("none", 4'b1111, 4'b1111);
    expect_result("none", 1, 0, 2'd0, 2'd3);
    ack("none");

    // Reset in the middle of SAMPLE (after one failed sample).
    randomval = 32'h0000_0000;
    request("midreset", 4'b1111, 4'b0111);
    check("midreset_strobe", 32'(lfsr_update), 32'd1);
    @(posedge clk); #1;
    check("midreset_still_sampling", 32'(lfsr_update), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("midreset");
    rst = 1'b1;

    request("post_reset_invalid", 4'b1011, 4'b0000);
    expect_result("post_reset_invalid", 1, 0, 2'd2, 2'd0);
    ack("post_reset_invalid");

    randomval = 32'h1234_5671;
    request("post_reset_random", 4'b1111, 4'b0000);
    expect_result("post_reset_random", 2, 1, 2'd1, 2'd1);
    ack("post_reset_random");

    // Retry count must start from zero again after the aborted request.
    randomval = 32'h0000_0010;
    request("post_reset_scan", 4'b1111, 4'b0111);
    expect_result("post_reset_scan", 5, 3, 2'd3, 2'd2);
    ack("post_reset_scan");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rand_victim_select.md
Name: rand_victim_select

Overview:
- Downstream consumer of the fetch-unit LFSR.
- Picks a replacement victim way for a set-associative fetch structure (I-cache / BTB) on a fill request.
- Prefers an invalid unlocked way. Otherwise it samples the LFSR for a random way, retrying past locked ways.
- Falls back to a deterministic wrap-around scan after bounded retries.
- Drives the LFSR update strobe so each sample consumes a fresh random value.

Parameters:
- WAYS, 4, associativity; power of two, >= 2.
- RAND_WIDTH, 32, width of the incoming LFSR value.
- MAX_RETRY, 3, random samples allowed before falling back to scan; >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low (0 = reset).
- req_valid  in  1  fill request.
- req_ready  out  1  block idle, can accept a request.
- way_valid  in  WAYS  per-way valid bits of the target set; sampled at acceptance.
- way_lock  in  WAYS  per-way lock/pinned bits; sampled at acceptance.
- randomval  in  RAND_WIDTH  current LFSR value.
- lfsr_update  out  1  advance-LFSR strobe.
- victim_valid  out  1  result available.
- victim_way  out  $clog2(WAYS)  selected way.
- victim_status  out  2  0 = INVALID_PICK, 1 = RANDOM, 2 = SCAN, 3 = NONE (all ways locked).
- victim_ack  in  1  consumer accepts the result.

Behaviour:
- Reset: rst=0 at a clock edge gives state IDLE, retry count 0, captured masks 0.
  - Output reset values: req_ready=1, lfsr_update=0, victim_valid=0, victim_way=0, victim_status=0.
  - Reset has priority in every state, including mid-SAMPLE and mid-DONE. The pending result is dropped and no ack is needed.
- States: IDLE, SAMPLE, SCAN, DONE. Outputs are registered or decoded from state; there is no combinational path from req_valid to victim_*.
- IDLE:
  - req_ready=1. On req_valid=1, capture way_valid and way_lock into registers. Later input changes are ignored until the next acceptance.
  - free = ~valid & ~lock.
  - If free != 0: victim_way = lowest set index of free, status INVALID_PICK, go to DONE. Result visible the cycle after acceptance.
  - Else if lock is all ones: victim_way=0, status NONE, go to DONE.
  - Else: go to SAMPLE with retry=0.
- SAMPLE:
  - req_ready=0.
  - cand = randomval[$clog2(WAYS)-1:0].
  - lfsr_update=1 for every SAMPLE cycle, so the next sample sees a new value.
  - If lock[cand]=0: victim_way=cand, status RANDOM, go to DONE.
  - Else retry++. If the incremented retry == MAX_RETRY, record last cand and go to SCAN; otherwise stay in SAMPLE.
- SCAN:
  - One cycle. Search from (last cand + 1) mod WAYS upward with wrap-around.
  - Pick the first unlocked way, status SCAN, go to DONE.
  - An unlocked way is guaranteed, because the all-locked case is filtered in IDLE.
- DONE:
  - victim_valid=1. victim_way and victim_status stay stable until victim_ack=1 is sampled.
  - Then go to IDLE, with req_ready=1 on the next cycle.
  - Back-to-back request: a new req_valid is accepted only in IDLE, i.e. at least one idle cycle between results.
- Latency:
  - INVALID_PICK / NONE: 1 cycle after acceptance.
  - RANDOM on first sample: 2 cycles.
  - Worst case: 1 + MAX_RETRY + 1 cycles.
- lfsr_update is 0 in all states except SAMPLE.
- Retry counter width: $clog2(MAX_RETRY+1). It never wraps, because the exit occurs at MAX_RETRY.
- Width rules: only the low $clog2(WAYS) bits of randomval are used. Upper bits are ignored (no lint-clean truncation warnings allowed).

Decomposition:
- Shared fetch package holds:
  - typedef for victim state (IDLE/SAMPLE/SCAN/DONE);
  - typedef for victim_status enum with the encodings above;
  - constant VICTIM_WAY_WIDTH = $clog2(WAYS) for the default config.
- One natural sub-module: rot_prio_enc. It is a rotating priority encoder (mask, start index) giving (index, found).
  - Used twice: start index 0 for the free-way pick in IDLE, and start index (cand+1) for SCAN.

Test Plan (WAYS=4, MAX_RETRY=3):
- way_valid=4'b1011, way_lock=0, req_valid pulse -> next cycle victim_valid=1, way=2, status=0; lfsr_update never 1.
- valid=4'b1111, lock=0, randomval low bits=2'b01 -> SAMPLE one cycle with lfsr_update=1; next cycle way=1, status=1.
- valid=4'b1111, lock=4'b0111, randomval low bits 0,1,2 on successive samples -> three lfsr_update pulses, SCAN from index 3 -> way=3, status=2, valid 5 cycles after acceptance.
- valid=4'b1111, lock=4'b1111 -> way=0, status=3, no lfsr_update.
- Hold victim_ack=0 for 10 cycles in DONE while toggling way_lock and randomval -> victim_way/status stable, req_ready=0. Ack -> IDLE next cycle.
- Assert rst=0 during SAMPLE -> next cycle all outputs at reset values. Release and issue a new request -> normal 1/2-cycle results.
